fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
Instruction-fetch sequencer that owns the architectural fetch PC and drives the branch predictor. It issues one instruction-cache read at a time, presents the returned word to the predictor, and pushes {inst, pc, pred_jump} into the instruction queue. It advances the PC to the predictor's next-PC and redirects on ROB flush, discarding any in-flight cache response.

Parameters:
RESET_PC, 32'h0, fetch PC loaded on reset
ADDR_W, 32, PC / address width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
rdy  in  1  global ready; all state frozen when low
rob_clear  in  1  mispredict flush from ROB
rob_set_pc  in  ADDR_W  redirect target, valid with rob_clear
ic_req  out  1  icache read request, held until ic_done
ic_addr  out  ADDR_W  icache read address
ic_done  in  1  one-cycle pulse, response valid
ic_inst  in  32  fetched instruction, valid with ic_done
pred_flag  out  1  predictor query valid
pred_inst  out  32  instruction under prediction
pred_cur_pc  out  ADDR_W  PC of that instruction
pred_pc  in  ADDR_W  predicted next PC (combinational from predictor)
pred_jump  in  1  predicted taken
iq_full  in  1  instruction queue cannot accept
iq_valid  out  1  one-cycle push into instruction queue
iq_inst  out  32  pushed instruction
iq_pc  out  ADDR_W  pushed PC
iq_pred_jump  out  1  pushed prediction

Behaviour:
- Reset (async, any state): pc=RESET_PC, state=IDLE, ic_req=0, ic_addr=0, iq_valid=0, iq_inst=0, iq_pc=0, iq_pred_jump=0, inst_r=0.
- rdy low: no register changes; outputs hold; ic_done/rob_clear ignored that cycle.
- States: IDLE, WAIT, PRED, DROP.
- IDLE: if !iq_full, ic_req<=1, ic_addr<=pc, go WAIT; else stay.
- WAIT: ic_req stays 1; on ic_done: inst_r<=ic_inst, ic_req<=0, go PRED.
- PRED: pred_flag=1, pred_inst=inst_r, pred_cur_pc=pc (combinational; 0 in all other states for flag, values don't-care). If !iq_full: iq_valid<=1, iq_inst<=inst_r, iq_pc<=pc, iq_pred_jump<=pred_jump, pc<=pred_pc, go IDLE. If iq_full: stay, no push.
- iq_valid is a pulse: cleared the cycle after it is set unless set again.
- Throughput: one instruction per 3 cycles minimum (IDLE→WAIT with 1-cycle ic_done latency → PRED→IDLE).
- rob_clear (highest priority, rdy high): pc<=rob_set_pc; iq_valid<=0.
  - From IDLE or PRED: go IDLE, ic_req<=0.
  - From WAIT with ic_done same cycle: response discarded, ic_req<=0, go IDLE.
  - From WAIT without ic_done: go DROP; ic_req and ic_addr held until ic_done.
  - In DROP: rob_clear updates pc again, stays DROP.
- DROP: on ic_done: ic_inst discarded, ic_req<=0, go IDLE.
- No push ever occurs in the cycle rob_clear is high.
- pc update width: ADDR_W, wraps naturally; no alignment check.

Test Plan:
- Reset with RESET_PC=0x0, iq_full=0, icache returns 0x00000013 after 1 cycle → ic_addr=0x0, iq_valid pulse, iq_pc=0x0, next ic_addr=0x4.
- JAL at pc 0x10, predictor returns pred_pc=0x40, pred_jump=1 → iq_pred_jump=1, iq_pc=0x10, next ic_addr=0x40.
- iq_full held high 5 cycles while in PRED → no iq_valid, pc unchanged; drop iq_full → single push next cycle.
- rob_clear with rob_set_pc=0x200 during WAIT, ic_done 3 cycles later → DROP, response discarded, no push, next ic_addr=0x200.
- rob_clear coincident with ic_done → no push, IDLE, next ic_addr=rob_set_pc.
- rdy low for 4 cycles mid-WAIT with ic_done pulsed → state/outputs frozen, pulse ignored; rst asserted mid-PRED → immediate return to reset values.

Source files
------------

// File: rtl/fetch_ctrl_if.sv
// Fetch-side bus bundle: ROB redirect, icache read channel, branch predictor
// query and instruction-queue push, seen from the fetch controller (master).
interface fetch_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              rdy;
    logic              rob_clear;
    logic [ADDR_W-1:0] rob_set_pc;

    logic              ic_req;
    logic [ADDR_W-1:0] ic_addr;
    logic              ic_done;
    logic [31:0]       ic_inst;

    logic              pred_flag;
    logic [31:0]       pred_inst;
    logic [ADDR_W-1:0] pred_cur_pc;
    logic [ADDR_W-1:0] pred_pc;
    logic              pred_jump;

    logic              iq_full;
    logic              iq_valid;
    logic [31:0]       iq_inst;
    logic [ADDR_W-1:0] iq_pc;
    logic              iq_pred_jump;

    modport master (
        input  rdy, rob_clear, rob_set_pc,
        input  ic_done, ic_inst,
        input  pred_pc, pred_jump,
        input  iq_full,
        output ic_req, ic_addr,
        output pred_flag, pred_inst, pred_cur_pc,
        output iq_valid, iq_inst, iq_pc, iq_pred_jump
    );

    modport slave (
        output rdy, rob_clear, rob_set_pc,
        output ic_done, ic_inst,
        output pred_pc, pred_jump,
        output iq_full,
        input  ic_req, ic_addr,
        input  pred_flag, pred_inst, pred_cur_pc,
        input  iq_valid, iq_inst, iq_pc, iq_pred_jump
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, issues one icache read at a
// time, queries the branch predictor and pushes the result into the IQ.
//
// state | meaning
// IDLE  | no read outstanding; issue read at pc when the IQ has room
// WAIT  | read outstanding, waiting for ic_done
// PRED  | instruction held in inst_q, predictor queried, push when IQ has room
// DROP  | read outstanding after a flush; response will be discarded
module fetch_ctrl #(
    parameter int              ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    fetch_ctrl_if.master  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        PRED = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] pc_q;
    logic [31:0]       inst_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else if (bus.rdy) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (!bus.rob_clear && !bus.iq_full) state_d = WAIT;
            WAIT: begin
                if (bus.rob_clear)    state_d = bus.ic_done ? IDLE : DROP;
                else if (bus.ic_done) state_d = PRED;
            end
            PRED: if (bus.rob_clear || !bus.iq_full) state_d = IDLE;
            DROP: if (bus.ic_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.pred_flag   = (state_q == PRED);
        bus.pred_inst   = inst_q;
        bus.pred_cur_pc = pc_q;
    end

    // Datapath registers; a flush always wins over push/issue in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q             <= RESET_PC;
            inst_q           <= '0;
            bus.ic_req       <= 1'b0;
            bus.ic_addr      <= '0;
            bus.iq_valid     <= 1'b0;
            bus.iq_inst      <= '0;
            bus.iq_pc        <= '0;
            bus.iq_pred_jump <= 1'b0;
        end else if (bus.rdy) begin
            bus.iq_valid <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.rob_clear) begin
                        pc_q       <= bus.rob_set_pc;
                        bus.ic_req <= 1'b0;
                    end else if (!bus.iq_full) begin
                        bus.ic_req  <= 1'b1;
                        bus.ic_addr <= pc_q;
                    end
                end
                WAIT: begin
                    if (bus.rob_clear) begin
                        pc_q <= bus.rob_set_pc;
                        if (bus.ic_done) bus.ic_req <= 1'b0;
                    end else if (bus.ic_done) begin
                        inst_q     <= bus.ic_inst;
                        bus.ic_req <= 1'b0;
                    end
                end
                PRED: begin
                    if (bus.rob_clear) begin
                        pc_q       <= bus.rob_set_pc;
                        bus.ic_req <= 1'b0;
                    end else if (!bus.iq_full) begin
                        bus.iq_valid     <= 1'b1;
                        bus.iq_inst      <= inst_q;
                        bus.iq_pc        <= pc_q;
                        bus.iq_pred_jump <= bus.pred_jump;
                        pc_q             <= bus.pred_pc;
                    end
                end
                DROP: begin
                    if (bus.rob_clear) pc_q <= bus.rob_set_pc;
                    if (bus.ic_done)   bus.ic_req <= 1'b0;
                end
                default: bus.ic_req <= 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: reactive icache/predictor models, a transaction-level
// reference of the fetch pipeline, directed scenarios then random traffic.
module tb_fetch_ctrl;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_ctrl_if #(.ADDR_W(AW)) bus ();

    fetch_ctrl #(.ADDR_W(AW), .RESET_PC(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    // Toy predictor: opcode 0x6f is taken, offset is sign-extended inst[31:20].
    function automatic logic pred_taken(input logic [31:0] inst);
        return inst[6:0] == 7'h6f;
    endfunction

    function automatic logic [31:0] pred_target(input logic [31:0] inst, input logic [31:0] pc);
        if (pred_taken(inst)) return pc + {{20{inst[31]}}, inst[31:20]};
        return pc + 32'd4;
    endfunction

    assign bus.pred_jump = pred_taken(bus.pred_inst);
    assign bus.pred_pc   = pred_target(bus.pred_inst, bus.pred_cur_pc);

    int vectors = 0;
    int miscompares = 0;
    int cyc_n = 0;
    int lat_cnt = 0;
    int lat_max = 0;
    bit rand_inst = 0;

    function automatic logic [31:0] imem(input logic [31:0] addr);
        logic [31:0] r;
        if (rand_inst) begin
            r = $urandom;
            return (r[1:0] == 2'b00) ? {r[31:7], 7'h6f} : {r[31:7], 7'h13};
        end
        if (addr == 32'h10) return 32'h0300_006f;
        return {addr[24:0], 7'h13};
    endfunction

    // Reference: pipeline described as "read outstanding / instruction held".
    logic [31:0] m_pc, m_addr, m_inst, m_iqi, m_iqpc;
    logic        m_req, m_drop, m_have, m_iqv, m_iqj;

    task automatic model_reset();
        m_pc = 32'h0; m_addr = 0; m_inst = 0; m_iqi = 0; m_iqpc = 0;
        m_req = 0; m_drop = 0; m_have = 0; m_iqv = 0; m_iqj = 0;
    endtask

    task automatic model_step();
        if (!bus.rdy) return;
        m_iqv = 0;
        if (!m_req && !m_have) begin
            if (bus.rob_clear) m_pc = bus.rob_set_pc;
            else if (!bus.iq_full) begin
                m_req = 1; m_addr = m_pc;
            end
        end else if (m_req) begin
            if (bus.rob_clear) begin
                m_pc = bus.rob_set_pc;
                if (bus.ic_done) begin m_req = 0; m_drop = 0; end
                else m_drop = 1;
            end else if (bus.ic_done) begin
                if (!m_drop) begin m_have = 1; m_inst = bus.ic_inst; end
                m_req = 0; m_drop = 0;
            end
        end else begin
            if (bus.rob_clear) begin
                m_pc = bus.rob_set_pc; m_have = 0;
            end else if (!bus.iq_full) begin
                m_iqv = 1; m_iqi = m_inst; m_iqpc = m_pc; m_iqj = pred_taken(m_inst);
                m_pc = pred_target(m_inst, m_pc);
                m_have = 0;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    logic [31:0] push_pc[$], push_inst[$], req_log[$];
    logic        push_jump[$];
    int          push_cyc[$];
    logic        prev_req = 0;
    logic        prev_rdy = 1;

    task automatic clear_logs();
        push_pc.delete(); push_inst.delete(); push_jump.delete(); push_cyc.delete(); req_log.delete();
    endtask

    task automatic compare();
        check("ic_req", bus.ic_req, m_req);
        check("ic_addr", bus.ic_addr, m_addr);
        check("iq_valid", bus.iq_valid, m_iqv);
        check("iq_inst", bus.iq_inst, m_iqi);
        check("iq_pc", bus.iq_pc, m_iqpc);
        check("iq_pred_jump", bus.iq_pred_jump, m_iqj);
        check("pred_flag", bus.pred_flag, m_have);
        if (m_have) begin
            check("pred_inst", bus.pred_inst, m_inst);
            check("pred_cur_pc", bus.pred_cur_pc, m_pc);
        end
        if (bus.iq_valid && prev_rdy) begin
            push_pc.push_back(bus.iq_pc); push_inst.push_back(bus.iq_inst);
            push_jump.push_back(bus.iq_pred_jump); push_cyc.push_back(cyc_n);
        end
        if (bus.ic_req && !prev_req) req_log.push_back(bus.ic_addr);
        prev_req = bus.ic_req;
        prev_rdy = bus.rdy;
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        @(negedge clk);
        cyc_n++;
        compare();
    endtask

    task automatic drive_icache();
        if (bus.ic_req && lat_cnt == 0) begin
            bus.ic_done = 1'b1;
            bus.ic_inst = imem(bus.ic_addr);
            lat_cnt = $urandom_range(lat_max, 0);
        end else begin
            bus.ic_done = 1'b0;
            bus.ic_inst = $urandom;
            if (bus.ic_req && lat_cnt > 0) lat_cnt--;
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            drive_icache();
            cyc();
        end
    endtask

    task automatic wait_pred();
        int n = 0;
        while (!bus.pred_flag && n < 40) begin drive_icache(); cyc(); n++; end
        check("wait_pred_timeout", bus.pred_flag, 1);
    endtask

    task automatic wait_req();
        int n = 0;
        while (!bus.ic_req && n < 40) begin drive_icache(); cyc(); n++; end
        check("wait_req_timeout", bus.ic_req, 1);
    endtask

    task automatic async_reset();
        rst = 1'b1;
        #1;
        model_reset();
        compare();
        check("rst_ic_req", bus.ic_req, 0);
        check("rst_iq_valid", bus.iq_valid, 0);
        check("rst_pred_flag", bus.pred_flag, 0);
        check("rst_ic_addr", bus.ic_addr, 0);
        @(negedge clk);
        rst = 1'b0;
        lat_cnt = 0;
        compare();
    endtask

    logic [31:0] exp_pc, a_addr;

    initial begin
        bus.rdy = 1; bus.rob_clear = 0; bus.rob_set_pc = 0; bus.iq_full = 0;
        bus.ic_done = 0; bus.ic_inst = 0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        compare();
        check("reset_ic_req", bus.ic_req, 0);
        check("reset_iq_valid", bus.iq_valid, 0);
        check("reset_ic_addr", bus.ic_addr, 0);

        // Straight-line fetch from 0, JAL at 0x10 redirects to 0x40.
        clear_logs();
        step(20);
        check("t1_push_cnt", push_pc.size() >= 6, 1);
        check("t1_req_cnt", req_log.size() >= 6, 1);
        if (push_pc.size() >= 6 && req_log.size() >= 6) begin
            check("t1_push0_pc", push_pc[0], 32'h0);
            check("t1_push0_inst", push_inst[0], 32'h0000_0013);
            check("t1_push0_jump", push_jump[0], 0);
            check("t1_throughput", push_cyc[1] - push_cyc[0], 3);
            check("t1_second_addr", req_log[1], 32'h4);
            check("t1_jal_pc", push_pc[4], 32'h10);
            check("t1_jal_jump", push_jump[4], 1);
            check("t1_jal_inst", push_inst[4], 32'h0300_006f);
            check("t1_jal_target", req_log[5], 32'h40);
        end

        // IQ full held in PRED: no push, pc held, single push after release.
        wait_pred();
        exp_pc = m_pc;
        bus.iq_full = 1;
        for (int i = 0; i < 5; i++) begin
            drive_icache(); cyc();
            check("full_no_push", bus.iq_valid, 0);
            check("full_pc_held", bus.pred_cur_pc, exp_pc);
        end
        bus.iq_full = 0;
        drive_icache(); cyc();
        check("full_release_push", bus.iq_valid, 1);
        check("full_release_pc", bus.iq_pc, exp_pc);
        drive_icache(); cyc();
        check("full_pulse_clear", bus.iq_valid, 0);

        // Flush during WAIT, response 3 cycles later is dropped.
        lat_cnt = 5;
        wait_req();
        clear_logs();
        bus.rob_clear = 1; bus.rob_set_pc = 32'h200; bus.ic_done = 0;
        cyc();
        bus.rob_clear = 0;
        check("drop_req_held", bus.ic_req, 1);
        lat_cnt = 2;
        for (int i = 0; i < 3; i++) begin
            drive_icache(); cyc();
            check("drop_no_push", bus.iq_valid, 0);
        end
        check("drop_req_released", bus.ic_req, 0);
        step(6);
        check("drop_req_cnt", req_log.size() >= 1 && push_pc.size() >= 1, 1);
        if (req_log.size() >= 1 && push_pc.size() >= 1) begin
            check("drop_next_addr", req_log[0], 32'h200);
            check("drop_first_push", push_pc[0], 32'h200);
        end

        // Flush coincident with ic_done.
        lat_cnt = 0;
        wait_req();
        drive_icache();
        bus.rob_clear = 1; bus.rob_set_pc = 32'h300;
        cyc();
        bus.rob_clear = 0;
        check("coinc_no_push", bus.iq_valid, 0);
        check("coinc_req_drop", bus.ic_req, 0);
        clear_logs();
        step(4);
        check("coinc_req_cnt", req_log.size() >= 1, 1);
        if (req_log.size() >= 1) check("coinc_next_addr", req_log[0], 32'h300);

        // rdy low for 4 cycles mid-WAIT, ic_done pulse ignored.
        lat_cnt = 9;
        wait_req();
        a_addr = m_addr;
        bus.rdy = 0;
        for (int i = 0; i < 4; i++) begin
            bus.ic_done = (i == 1);
            bus.ic_inst = 32'hdead_beef;
            cyc();
            check("frz_req", bus.ic_req, 1);
            check("frz_addr", bus.ic_addr, a_addr);
            check("frz_pred", bus.pred_flag, 0);
        end
        bus.rdy = 1;
        lat_cnt = 0;
        clear_logs();
        step(3);
        check("frz_push_cnt", push_inst.size(), 1);
        if (push_inst.size() >= 1) check("frz_push_inst", push_inst[0], imem(a_addr));

        // Asynchronous reset while in PRED.
        wait_pred();
        bus.ic_done = 0;
        async_reset();

        // Random traffic.
        lat_max = 3;
        rand_inst = 1;
        for (int i = 0; i < 4000; i++) begin
            bus.rdy = ($urandom % 10) != 0;
            bus.rob_clear = ($urandom % 20) == 0;
            bus.rob_set_pc = $urandom;
            if ($urandom % 8 == 0) bus.iq_full = ~bus.iq_full;
            if ($urandom % 700 == 0) begin
                bus.ic_done = 0;
                async_reset();
            end else begin
                drive_icache();
                cyc();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
